// File: rtl/serial_shr_receiver.sv
// -----------------------------------------------------------------------------
// serial_shr_receiver
//
// Rebuilds a parallel word from the LSB-first serial stream that a shift-right
// register emits on right_carry. Bits qualified by bit_valid enter the shift
// register at the MSB. After WIDTH bits the first bit received sits in bit 0.
// The finished word is offered on a valid/ready port.
//
// Optional build macro: SERIAL_SHR_RECEIVER_PARITY_CHECK_EN
//   When it is defined, one extra even-parity beat follows the WIDTH data bits,
//   and parity_err reports the check for the word on data_out.
//   When it is undefined, parity_err is tied 0.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   clr         synchronous clear, highest priority
//   bit_in      serial data bit, LSB first
//   bit_valid   bit_in is sampled on this edge
//   data_out    last completed word (registered)
//   data_valid  data_out holds an undelivered word
//   data_ready  consumer accepts data_out when data_valid=1
//   busy        a word is partially received
//   overrun     sticky: a completed word was dropped
//   parity_err  parity result for the word on data_out
//
// State   | Meaning
// --------+----------------------------------------------------------
// IDLE    | no partial word; next accepted bit starts a new word
// SHIFT   | collecting data bits; cnt_q = bits accepted so far
// PARITY  | (parity build only) data bits held, waiting for parity bit
// -----------------------------------------------------------------------------
module serial_shr_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic [WIDTH-1:0] word;
    logic             transfer;

`ifdef SERIAL_SHR_RECEIVER_PARITY_CHECK_EN
    logic             parity_err_q, parity_err_d;
    logic             perr;
`endif

    always_comb begin
        shifted      = {bit_in, shreg_q[WIDTH-1:1]};
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        complete     = 1'b0;
        word         = shreg_q;
        transfer     = data_valid_q & data_ready;
`ifdef SERIAL_SHR_RECEIVER_PARITY_CHECK_EN
        parity_err_d = parity_err_q;
        perr         = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bit_valid) begin
                    shreg_d = shifted;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    shreg_d = shifted;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
`ifdef SERIAL_SHR_RECEIVER_PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d  = IDLE;
                        complete = 1'b1;
                        word     = shifted;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef SERIAL_SHR_RECEIVER_PARITY_CHECK_EN
            PARITY: begin
                // Even parity: XOR over data and parity bit is 0 when clean.
                if (bit_valid) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                    word     = shreg_q;
                    perr     = (^shreg_q) ^ bit_in;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (transfer) begin
            data_valid_d = 1'b0;
        end

        // A completion loads only if the output slot is free or is being
        // drained on this same edge; otherwise the new word is dropped.
        if (complete) begin
            if (!data_valid_q || data_ready) begin
                data_out_d   = word;
                data_valid_d = 1'b1;
`ifdef SERIAL_SHR_RECEIVER_PARITY_CHECK_EN
                parity_err_d = perr;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (clr) begin
            state_d      = IDLE;
            cnt_d        = '0;
            shreg_d      = '0;
            data_out_d   = '0;
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
`ifdef SERIAL_SHR_RECEIVER_PARITY_CHECK_EN
            parity_err_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SERIAL_SHR_RECEIVER_PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/serial_shr_receiver.md
Name: serial_shr_receiver

Overview:
- Receiving end of the LSB-first serial stream that our shift-right registers emit on right_carry.
- Collects WIDTH serial bits, qualified by bit_valid, into a shift register and rebuilds the parallel word.
- Presents the word on a valid/ready output port.
- Sits between a shr-based transmitter register and any parallel consumer (register ld input, FIFO, datapath).

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..16.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous clear; highest priority over all other inputs.
- bit_in  input  1  serial data bit, LSB of the word first.
- bit_valid  input  1  bit_in is sampled on this clock edge.
- data_out  output  WIDTH  last completed word (registered).
- data_valid  output  1  data_out holds an undelivered word.
- data_ready  input  1  consumer accepts data_out when data_valid=1.
- busy  output  1  a word is partially received (state != IDLE).
- overrun  output  1  sticky: a completed word was dropped.
- parity_err  output  1  parity result for the word currently on data_out.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, bit counter=0, shift reg=0, data_out=0, data_valid=0, busy=0, overrun=0, parity_err=0.
- clr=1 at a clock edge: same values as reset, regardless of bit_valid or data_ready. A partial word is discarded.
- Shift rule on each accepted bit: shreg <= {bit_in, shreg[WIDTH-1:1]}. Data enters at the MSB and moves toward the LSB, so after WIDTH bits the first bit received is in bit 0.
- Bit counter width is clog2(WIDTH+1). It counts accepted bits of the current word.
- FSM states:
  - IDLE: bit_valid=1 -> shift, cnt=1, go to SHIFT. Otherwise hold.
  - SHIFT: bit_valid=1 -> shift, cnt+1. When the accepted bit is bit number WIDTH (cnt==WIDTH-1 before the edge), the word is complete: reset cnt to 0 and go to IDLE. With PARITY_CHECK_EN, go to PARITY instead.
  - SHIFT with bit_valid=0: hold everything. There is no timeout; gaps of any length are legal.
  - PARITY (only with macro): described under Optional Feature.
- Completion edge:
  - The assembled word, including the bit sampled on this edge, is written to data_out.
  - data_valid=1 from the next cycle. Latency: final data bit sampled at edge N, data_valid high after edge N.
- Output handshake:
  - A transfer occurs on any edge with data_valid=1 and data_ready=1.
  - After a transfer with no new completion on the same edge, data_valid=0.
  - data_out is stable while data_valid=1 and no transfer has occurred.
  - data_ready is ignored while data_valid=0.
- Completion with data_valid=1 and data_ready=0 (overrun):
  - The new word is dropped; data_out and data_valid are unchanged.
  - overrun=1, held until clr or reset.
- Completion on the same edge as a transfer: the new word loads, data_valid stays 1, no overrun.
- Input acceptance: bit_valid is always accepted. There is no back-pressure on the serial side.
- busy=1 in SHIFT and PARITY, 0 in IDLE.

Optional Feature:
- Macro: SERIAL_SHR_RECEIVER_PARITY_CHECK_EN.
- Defined:
  - After the WIDTH data bits, the FSM enters PARITY and waits for one more bit_valid beat carrying an even parity bit.
  - On that beat, completion and output handshake proceed as above, using the held data bits.
  - parity_err is loaded with (XOR of data bits) XOR parity bit; 1 means error.
  - parity_err is updated only when data_out is updated. It is cleared by clr or reset.
  - The word is delivered even when parity_err=1.
- Not defined: no PARITY state, parity_err is tied 0, and completion happens on data bit WIDTH.

Test Plan:
- Reset: rst_n low mid-simulation -> all outputs 0 within the same cycle, asynchronously. After release, the first edge with bit_valid=0 -> still IDLE, busy=0.
- Single word: WIDTH=4, data_ready=1, send 1,1,0,1 on consecutive edges -> busy=1 after edge 1; data_out=4'hB and data_valid=1 after edge 4; data_valid=0 one cycle later.
- Gapped input plus held output: send 0,1 (gap 3 cycles) 1,0 with data_ready=0 -> data_out=4'h6, data_valid held for 5 cycles. Pulse data_ready -> data_valid=0 on the next cycle.
- Overrun: complete 4'h6 with data_ready=0, then send 4'hA (bits 0,1,0,1) -> data_out stays 6, overrun=1. Raise data_ready -> 6 is consumed, overrun remains 1.
- clr mid-word: send 2 bits, assert clr on the same edge as a third bit_valid -> busy=0, counter 0, overrun=0. Then send 4'h3 -> data_out=4'h3 exactly after 4 new bits.
- Parity (macro on): send 1,0,1,1 then parity 1 -> data_out=4'hD, parity_err=0. Send the same data with parity 0 -> parity_err=1, data_out=4'hD.
